cv32e41s_rf_wb_stage: RTL and testbench
=======================================

// Module: cv32e41s_rf_wb_stage
// PURPOSE
// Write-back stage directly upstream of the integer register file. Accepts results from EX/MEM
// over valid/ready, holds them in a WB register plus one skid entry, and drives the regfile
// write port (waddr/wdata/we) together with dummy_instr_wb/hint_instr_wb. Also exposes the WB
// entry as a forwarding source to ID. Optionally appends 6 ECC check bits to the write data.
// PARAMETERS
// RV32    RV32I  RV32I: 32 GPRs; RV32E: 16 GPRs, writes to x16..x31 are suppressed and flagged
// WDATA_W 32     architectural result width; rf_wdata_o is REGFILE_WORD_WIDTH (32, or 38 w/ ECC)
// PORTS
// clk              in   1   clock
// rst_n            in   1   asynchronous active-low reset
// ex_valid_i       in   1   upstream result valid
// ex_ready_o       out  1   stage can accept (registered: = !skid_valid)
// ex_rf_we_i       in   1   result writes a GPR
// ex_rf_waddr_i    in   5   destination register
// ex_rf_wdata_i    in   32  result data
// ex_dummy_i       in   1   result belongs to a dummy instruction
// ex_hint_i        in   1   result belongs to a hint instruction
// halt_wb_i        in   1   hold WB entry (no retire, no write)
// kill_wb_i        in   1   flush WB and skid entries
// rf_we_o          out  1   regfile write enable (combinational from WB reg)
// rf_waddr_o       out  5   regfile write address
// rf_wdata_o       out  REGFILE_WORD_WIDTH  regfile write data (ECC-extended if enabled)
// dummy_instr_wb_o out  1   WB entry is dummy (to regfile, gates x0 write)
// hint_instr_wb_o  out  1   WB entry is hint (to regfile, gates x0 write)
// wb_valid_o       out  1   WB register holds a valid entry
// fwd_valid_o      out  1   WB entry usable for forwarding (wb_valid & rf_we & waddr!=0)
// fwd_waddr_o      out  5   forwarding address
// fwd_wdata_o      out  32  forwarding data (unencoded)
// rf_addr_err_o    out  1   1-cycle pulse: RV32E write to x16..x31 suppressed at retire
// BEHAVIOUR
// - Reset: wb_valid=0, skid_valid=0, ex_ready_o=1, all data regs 0; rf_we_o=0, fwd_valid_o=0,
//   rf_addr_err_o=0, dummy/hint outputs 0.
// - Accept: ex_valid_i & ex_ready_o. Retire: wb_valid & !halt_wb_i & !kill_wb_i.
// - Accepted entry goes to WB if WB empty or WB retiring this cycle and skid empty; else to skid.
// - On retire with skid valid: skid -> WB next cycle; new accept (if any) -> skid. Order is strict FIFO.
// - Latency: accept in cycle N into empty stage -> rf_we_o asserted in cycle N+1 (absent halt).
// - rf_we_o = wb_valid & wb_rf_we & !halt_wb_i & !kill_wb_i & addr_ok, where addr_ok is 0 if
//   waddr==0 and neither dummy nor hint, or RV32E and waddr[4]=1. Exactly one write per entry.
// - rf_addr_err_o pulses in the retire cycle of an entry suppressed only by the RV32E check.
// - kill_wb_i: same-cycle write suppressed; next cycle wb_valid=0, skid_valid=0, ex_ready_o=1;
//   a same-cycle accept is discarded. Kill wins over halt and over accept.
// - halt_wb_i with WB and skid full: ex_ready_o=0, state frozen, outputs stable.
// - dummy/hint_instr_wb_o reflect the WB entry; forced 0 when !wb_valid.
// - Async reset mid-operation: entries dropped immediately, rf_we_o deasserts without a clock.
// CONFIGURATION
// CV32E41S_RF_ECC_EN defined: REGFILE_WORD_WIDTH=38; rf_wdata_o = {chk[5:0], data[31:0]},
//   chk[k] = (XOR of data[i] for i%6==k) ^ P[k], P=6'b10_1010 (data 0 -> 6'b10_1010, matches RF reset).
// Not defined: REGFILE_WORD_WIDTH=32, rf_wdata_o = data; no check-bit logic.
// TESTING
// 1 Accept x5=0xDEADBEEF, no halt -> next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, fwd_valid_o=1.
// 2 Non-dummy write x0=0x1234 -> rf_we_o=0, fwd_valid_o=0; same with ex_dummy_i=1 -> rf_we_o=1,
//   dummy_instr_wb_o=1, waddr=0.
// 3 halt_wb_i held, accept A(x1) then B(x2) -> ex_ready_o=0 after B; release halt -> x1 written, then
//   x2 next cycle, ex_ready_o=1 again; C stalled during halt is accepted only after.
// 4 WB+skid full, kill_wb_i with ex_valid_i=1 -> no write that cycle, next cycle wb_valid_o=0,
//   ex_ready_o=1, no later write of any killed/discarded entry.
// 5 RV32=RV32E, write x17 -> rf_we_o=0, rf_addr_err_o=1 for one cycle; x15 written normally.
// 6 ECC_EN: data 0x0 -> rf_wdata_o=38'h2A_0000_0000; data 0x1 -> chk=6'b101011.

Source files
------------

// File: rtl/cv32e41s_rf_wb_stage.sv
// cv32e41s_rf_wb_stage
// Write-back stage in front of the integer register file: a WB register plus one
// skid entry (strict FIFO order), regfile write-port drive and a forwarding tap for ID.
// Optional feature macro: CV32E41S_RF_ECC_EN appends 6 check bits to rf_wdata_o.
// RV32 parameter: 0 = RV32I (32 GPRs), 1 = RV32E (16 GPRs, x16..x31 writes suppressed).

module cv32e41s_rf_wb_stage #(
    parameter int RV32    = 0,
    parameter int WDATA_W = 32,
`ifdef CV32E41S_RF_ECC_EN
    localparam int REGFILE_WORD_WIDTH = WDATA_W + 6
`else
    localparam int REGFILE_WORD_WIDTH = WDATA_W
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_valid_i,
    output logic                          ex_ready_o,
    input  logic                          ex_rf_we_i,
    input  logic [4:0]                    ex_rf_waddr_i,
    input  logic [WDATA_W-1:0]            ex_rf_wdata_i,
    input  logic                          ex_dummy_i,
    input  logic                          ex_hint_i,
    input  logic                          halt_wb_i,
    input  logic                          kill_wb_i,
    output logic                          rf_we_o,
    output logic [4:0]                    rf_waddr_o,
    output logic [REGFILE_WORD_WIDTH-1:0] rf_wdata_o,
    output logic                          dummy_instr_wb_o,
    output logic                          hint_instr_wb_o,
    output logic                          wb_valid_o,
    output logic                          fwd_valid_o,
    output logic [4:0]                    fwd_waddr_o,
    output logic [WDATA_W-1:0]            fwd_wdata_o,
    output logic                          rf_addr_err_o
);

    localparam bit IS_RV32E = (RV32 == 1);

    typedef struct packed {
        logic               we;
        logic [4:0]         waddr;
        logic [WDATA_W-1:0] wdata;
        logic               dummy;
        logic               hint;
    } entry_t;

    entry_t wb_q, wb_d, skid_q, skid_d, ex_entry;
    logic   wb_valid_q, wb_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, retire, zero_blocked, rv32e_blocked;

    assign ex_entry = '{we: ex_rf_we_i, waddr: ex_rf_waddr_i, wdata: ex_rf_wdata_i,
                        dummy: ex_dummy_i, hint: ex_hint_i};

    assign ex_ready_o = !skid_valid_q;
    assign accept     = ex_valid_i && ex_ready_o;
    assign retire     = wb_valid_q && !halt_wb_i && !kill_wb_i;

    // Next-state for the two-deep FIFO; kill empties both entries and drops any same-cycle accept.
    // WB empty implies skid empty, so an accept into an idle stage always lands in WB.
    always_comb begin
        wb_valid_d   = wb_valid_q;
        skid_valid_d = skid_valid_q;
        wb_d         = wb_q;
        skid_d       = skid_q;
        if (kill_wb_i) begin
            wb_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (retire) begin
            if (skid_valid_q) begin
                wb_d         = skid_q;
                wb_valid_d   = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = ex_entry;
            end else begin
                wb_valid_d = accept;
                if (accept) wb_d = ex_entry;
            end
        end else if (!wb_valid_q) begin
            wb_valid_d = accept;
            if (accept) wb_d = ex_entry;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = ex_entry;
        end
    end

    // WB and skid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            wb_q         <= '0;
            skid_q       <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            skid_valid_q <= skid_valid_d;
            wb_q         <= wb_d;
            skid_q       <= skid_d;
        end
    end

    assign zero_blocked  = (wb_q.waddr == 5'd0) && !wb_q.dummy && !wb_q.hint;
    assign rv32e_blocked = IS_RV32E && wb_q.waddr[4];

    assign rf_we_o          = retire && wb_q.we && !zero_blocked && !rv32e_blocked;
    assign rf_addr_err_o    = retire && wb_q.we && rv32e_blocked;
    assign rf_waddr_o       = wb_q.waddr;
    assign dummy_instr_wb_o = wb_valid_q && wb_q.dummy;
    assign hint_instr_wb_o  = wb_valid_q && wb_q.hint;
    assign wb_valid_o       = wb_valid_q;
    assign fwd_valid_o      = wb_valid_q && wb_q.we && (wb_q.waddr != 5'd0);
    assign fwd_waddr_o      = wb_q.waddr;
    assign fwd_wdata_o      = wb_q.wdata;

`ifdef CV32E41S_RF_ECC_EN
    localparam logic [5:0] ECC_PAT = 6'b10_1010;
    logic [5:0] chk;

    // Check bit k covers data bits i with i%6 == k; the inversion pattern makes all-zero data
    // encode to the register file's reset word.
    always_comb begin
        chk = ECC_PAT;
        for (int unsigned i = 0; i < WDATA_W; i++) begin
            chk[i % 6] = chk[i % 6] ^ wb_q.wdata[i];
        end
    end

    assign rf_wdata_o = {chk, wb_q.wdata};
`else
    assign rf_wdata_o = wb_q.wdata;
`endif

endmodule

// File: tb/tb_cv32e41s_rf_wb_stage.sv
// Testbench for cv32e41s_rf_wb_stage: directed table, hand sequences (RV32E, ECC, async reset)
// and randomized traffic against a queue-based reference model. Two DUTs: RV32I and RV32E.

module tb_cv32e41s_rf_wb_stage;

`ifdef CV32E41S_RF_ECC_EN
    localparam int RW = 38;
`else
    localparam int RW = 32;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ex_valid = 0, ex_we = 0, ex_dummy = 0, ex_hint = 0, halt = 0, kill = 0;
    logic [4:0]  ex_waddr = '0;
    logic [31:0] ex_wdata = '0;

    logic          i_ready, i_we, i_dm, i_ht, i_wbv, i_fwd, i_err;
    logic [4:0]    i_wa, i_fwa;
    logic [RW-1:0] i_wd;
    logic [31:0]   i_fwd_d;
    logic          e_ready, e_we, e_dm, e_ht, e_wbv, e_fwd, e_err;
    logic [4:0]    e_wa, e_fwa;
    logic [RW-1:0] e_wd;
    logic [31:0]   e_fwd_d;

    cv32e41s_rf_wb_stage #(.RV32(0)) dut_i (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(i_ready),
        .ex_rf_we_i(ex_we), .ex_rf_waddr_i(ex_waddr), .ex_rf_wdata_i(ex_wdata),
        .ex_dummy_i(ex_dummy), .ex_hint_i(ex_hint), .halt_wb_i(halt), .kill_wb_i(kill),
        .rf_we_o(i_we), .rf_waddr_o(i_wa), .rf_wdata_o(i_wd), .dummy_instr_wb_o(i_dm),
        .hint_instr_wb_o(i_ht), .wb_valid_o(i_wbv), .fwd_valid_o(i_fwd), .fwd_waddr_o(i_fwa),
        .fwd_wdata_o(i_fwd_d), .rf_addr_err_o(i_err));

    cv32e41s_rf_wb_stage #(.RV32(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(e_ready),
        .ex_rf_we_i(ex_we), .ex_rf_waddr_i(ex_waddr), .ex_rf_wdata_i(ex_wdata),
        .ex_dummy_i(ex_dummy), .ex_hint_i(ex_hint), .halt_wb_i(halt), .kill_wb_i(kill),
        .rf_we_o(e_we), .rf_waddr_o(e_wa), .rf_wdata_o(e_wd), .dummy_instr_wb_o(e_dm),
        .hint_instr_wb_o(e_ht), .wb_valid_o(e_wbv), .fwd_valid_o(e_fwd), .fwd_waddr_o(e_fwa),
        .fwd_wdata_o(e_fwd_d), .rf_addr_err_o(e_err));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoded regfile word from the check-bit rule: bit k = XOR of data bits with i%6==k, xor pattern.
    function automatic logic [RW-1:0] enc(input logic [31:0] d);
`ifdef CV32E41S_RF_ECC_EN
        logic [5:0] c;
        logic [5:0] p;
        p = 6'b10_1010;
        for (int k = 0; k < 6; k++) begin
            c[k] = p[k];
            for (int i = k; i < 32; i += 6) c[k] = c[k] ^ d[i];
        end
        return {c, d};
`else
        return d;
`endif
    endfunction

    // Reference model: the stage is a FIFO of at most two results, head = WB entry.
    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        dm;
        logic        ht;
    } ent_t;
    ent_t mq[$];

    task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic dm, input logic ht, input logic hl, input logic kl);
        @(negedge clk);
        ex_valid = v; ex_we = we; ex_waddr = a; ex_wdata = d;
        ex_dummy = dm; ex_hint = ht; halt = hl; kill = kl;
        #1;
    endtask

    task automatic advance();
        logic acc, ret;
        ent_t n;
        acc = ex_valid && (mq.size() < 2);
        ret = (mq.size() > 0) && !halt && !kill;
        n = '{we: ex_we, a: ex_waddr, d: ex_wdata, dm: ex_dummy, ht: ex_hint};
        @(posedge clk);
        if (kill) mq.delete();
        else begin
            if (ret) void'(mq.pop_front());
            if (acc) mq.push_back(n);
        end
    endtask

    task automatic check_inst(input string tag, input bit e, input logic ready, input logic we,
                              input logic [4:0] wa, input logic [RW-1:0] wd, input logic wbv,
                              input logic fwd, input logic dm, input logic ht, input logic err);
        logic wbv_x, writes, live;
        ent_t f;
        wbv_x = mq.size() > 0;
        f = wbv_x ? mq[0] : '{we: 1'b0, a: 5'd0, d: 32'd0, dm: 1'b0, ht: 1'b0};
        live = wbv_x && !halt && !kill;
        writes = f.we && (f.a != 0 || f.dm || f.ht) && !(e && f.a >= 16);
        check({tag, ".ready"}, 64'(ready), 64'(mq.size() < 2));
        check({tag, ".wb_valid"}, 64'(wbv), 64'(wbv_x));
        check({tag, ".rf_we"}, 64'(we), 64'(live && writes));
        check({tag, ".fwd_valid"}, 64'(fwd), 64'(wbv_x && f.we && f.a != 0));
        check({tag, ".dummy"}, 64'(dm), 64'(wbv_x && f.dm));
        check({tag, ".hint"}, 64'(ht), 64'(wbv_x && f.ht));
        check({tag, ".addr_err"}, 64'(err), 64'(live && f.we && e && f.a >= 16));
        if (live && writes) begin
            check({tag, ".waddr"}, 64'(wa), 64'(f.a));
            check({tag, ".wdata"}, 64'(wd), 64'(enc(f.d)));
        end
    endtask

    typedef struct {
        logic v, we; logic [4:0] a; logic [31:0] d; logic dm, ht, hl, kl;
        logic x_ready, x_we; logic [4:0] x_a; logic [31:0] x_d; logic x_wbv, x_fwd, x_dm;
    } vec_t;

    function automatic vec_t mk(input bit v, input bit we, input int a, input int unsigned d,
                                input bit dm, input bit hl, input bit kl, input bit r,
                                input bit w, input int xa, input int unsigned xd, input bit wbv,
                                input bit fwd, input bit xdm);
        vec_t t;
        t.v = v; t.we = we; t.a = 5'(a); t.d = d; t.dm = dm; t.ht = 1'b0; t.hl = hl; t.kl = kl;
        t.x_ready = r; t.x_we = w; t.x_a = 5'(xa); t.x_d = xd;
        t.x_wbv = wbv; t.x_fwd = fwd; t.x_dm = xdm;
        return t;
    endfunction

    vec_t tbl[17];

    initial begin
        // v we a  d            dm hl kl | rdy we xa xd           wbv fwd dm
        tbl[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,            0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 1, 1, 0);
        tbl[2]  = mk(1, 1, 0, 32'h1234,     0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 32'h5678,     1, 0, 0, 1, 0, 0, 0,            1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,            0, 0, 0, 1, 1, 0, 32'h5678,     1, 0, 1);
        tbl[5]  = mk(1, 1, 1, 32'hA1,       0, 1, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[6]  = mk(1, 1, 2, 32'hB2,       0, 1, 0, 1, 0, 0, 0,            1, 1, 0);
        tbl[7]  = mk(1, 1, 3, 32'hC3,       0, 1, 0, 0, 0, 0, 0,            1, 1, 0);
        tbl[8]  = mk(1, 1, 3, 32'hC3,       0, 0, 0, 0, 1, 1, 32'hA1,       1, 1, 0);
        tbl[9]  = mk(1, 1, 3, 32'hC3,       0, 0, 0, 1, 1, 2, 32'hB2,       1, 1, 0);
        tbl[10] = mk(0, 0, 0, 0,            0, 0, 0, 1, 1, 3, 32'hC3,       1, 1, 0);
        tbl[11] = mk(1, 1, 4, 32'hD4,       0, 1, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[12] = mk(1, 1, 6, 32'hE6,       0, 1, 0, 1, 0, 0, 0,            1, 1, 0);
        tbl[13] = mk(1, 1, 7, 32'hF7,       0, 1, 1, 0, 0, 0, 0,            1, 1, 0);
        tbl[14] = mk(1, 1, 8, 32'h88,       0, 0, 1, 1, 0, 0, 0,            0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0);

        // Reset state
        #3;
        check("rst.ready", 64'(i_ready), 64'd1);
        check("rst.wb_valid", 64'(i_wbv), 64'd0);
        check("rst.rf_we", 64'(i_we), 64'd0);
        check("rst.fwd_valid", 64'(i_fwd), 64'd0);
        check("rst.addr_err", 64'(e_err), 64'd0);
        check("rst.dummy_hint", 64'({i_dm, i_ht}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: write, x0 gating, halt/skid ordering, kill
        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].we, tbl[k].a, tbl[k].d, tbl[k].dm, tbl[k].ht, tbl[k].hl, tbl[k].kl);
            check($sformatf("tbl%0d.ready", k), 64'(i_ready), 64'(tbl[k].x_ready));
            check($sformatf("tbl%0d.rf_we", k), 64'(i_we), 64'(tbl[k].x_we));
            check($sformatf("tbl%0d.wb_valid", k), 64'(i_wbv), 64'(tbl[k].x_wbv));
            check($sformatf("tbl%0d.fwd_valid", k), 64'(i_fwd), 64'(tbl[k].x_fwd));
            check($sformatf("tbl%0d.dummy", k), 64'(i_dm), 64'(tbl[k].x_dm));
            if (tbl[k].x_we) begin
                check($sformatf("tbl%0d.waddr", k), 64'(i_wa), 64'(tbl[k].x_a));
                check($sformatf("tbl%0d.wdata", k), 64'(i_wd), 64'(enc(tbl[k].x_d)));
            end
            advance();
        end

        // RV32E: x17 suppressed with a one-cycle error pulse, x15 written
        drive(1, 1, 5'd17, 32'h1717, 0, 0, 0, 0); advance();
        drive(1, 1, 5'd15, 32'h1515, 0, 0, 0, 0);
        check("e.x17.rf_we", 64'(e_we), 64'd0);
        check("e.x17.addr_err", 64'(e_err), 64'd1);
        check("i.x17.rf_we", 64'(i_we), 64'd1);
        check("i.x17.addr_err", 64'(i_err), 64'd0);
        advance();
        drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        check("e.x15.addr_err", 64'(e_err), 64'd0);
        check("e.x15.rf_we", 64'(e_we), 64'd1);
        check("e.x15.waddr", 64'(e_wa), 64'd15);
        advance();

        // ECC encoding of data 0 and 1
        drive(1, 1, 5'd1, 32'h0, 0, 0, 0, 0); advance();
        drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 0);
`ifdef CV32E41S_RF_ECC_EN
        check("ecc.zero", 64'(i_wd), 64'h2A_0000_0000);
`else
        check("wdata.zero", 64'(i_wd), 64'h0);
`endif
        advance();
        drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
`ifdef CV32E41S_RF_ECC_EN
        check("ecc.one", 64'(i_wd), 64'h2B_0000_0001);
`else
        check("wdata.one", 64'(i_wd), 64'h1);
`endif
        advance();

        // Randomized traffic against the model, both configurations
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) != 0),
                  5'($urandom), $urandom, 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 15) == 0));
            check_inst("I", 1'b0, i_ready, i_we, i_wa, i_wd, i_wbv, i_fwd, i_dm, i_ht, i_err);
            check_inst("E", 1'b1, e_ready, e_we, e_wa, e_wd, e_wbv, e_fwd, e_dm, e_ht, e_err);
            check("fwd.data", 64'(i_fwd_d), mq.size() > 0 ? 64'(mq[0].d) : 64'(i_fwd_d));
            advance();
        end

        // Asynchronous reset with a pending write
        drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 1); advance();
        drive(1, 1, 5'd9, 32'h99, 0, 0, 0, 0); advance();
        drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        check("arst.pre_we", 64'(i_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst.rf_we", 64'(i_we), 64'd0);
        check("arst.wb_valid", 64'(i_wbv), 64'd0);
        check("arst.ready", 64'(i_ready), 64'd1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        check("arst.after_we", 64'(i_we), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
